// File: rtl/gray_step_decoder.sv
// gray_step_decoder: samples a gray code, converts it to binary and tracks
// step direction, wrapping position, illegal-jump errors and lock status.
module gray_step_decoder #(
  parameter int WIDTH  = 2,
  parameter int POS_W  = 8,
  parameter int ERR_W  = 4,
  parameter int RELOCK = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             in_valid,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_out,
  output logic [POS_W-1:0] pos_out,
  output logic             step_valid,
  output logic             dir_up,
  output logic             illegal,
  output logic [ERR_W-1:0] err_cnt,
  output logic             locked
);

  localparam int GW = $clog2(RELOCK + 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    TRACKING = 2'd1,
    FAULT    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q,   ref_d;
  logic [WIDTH-1:0] bin_q,   bin_d;
  logic [POS_W-1:0] pos_q,   pos_d;
  logic             step_q,  step_d;
  logic             dir_q,   dir_d;
  logic             ill_q,   ill_d;
  logic [ERR_W-1:0] err_q,   err_d;
  logic [GW-1:0]    good_q,  good_d;

  logic [WIDTH-1:0] bin_new;
  logic [WIDTH-1:0] delta;
  logic             is_hold, is_up, is_down, is_legal;
  logic [GW-1:0]    good_inc;
  logic [ERR_W-1:0] err_sat;

  // Gray-to-binary conversion and classification against the reference
  always_comb begin
    bin_new = '0;
    bin_new[WIDTH-1] = gray_in[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      bin_new[WIDTH-1-i] = bin_new[WIDTH-i] ^ gray_in[WIDTH-1-i];
    end
    delta    = bin_new - ref_q;
    is_hold  = (delta == '0);
    is_up    = (delta == WIDTH'(1));
    is_down  = (delta == '1);
    is_legal = is_hold | is_up | is_down;
    good_inc = good_q + 1'b1;
    err_sat  = (err_q == '1) ? err_q : err_q + 1'b1;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    bin_d   = bin_q;
    pos_d   = pos_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    ill_d   = 1'b0;
    err_d   = err_q;
    good_d  = good_q;

    if (in_valid) begin
      bin_d = bin_new;
      ref_d = bin_new;
      if (clr) begin
        pos_d = '0;
        err_d = '0;
        if (state_q == UNLOCKED) state_d = TRACKING;
      end else begin
        unique case (state_q)
          UNLOCKED: state_d = TRACKING;
          TRACKING: begin
            if (is_up) begin
              pos_d  = pos_q + 1'b1;
              step_d = 1'b1;
              dir_d  = 1'b1;
            end else if (is_down) begin
              pos_d  = pos_q - 1'b1;
              step_d = 1'b1;
              dir_d  = 1'b0;
            end else if (!is_hold) begin
              ill_d   = 1'b1;
              err_d   = err_sat;
              good_d  = '0;
              state_d = FAULT;
            end
          end
          FAULT: begin
            if (is_legal) begin
              if (good_inc == GW'(RELOCK)) begin
                good_d  = '0;
                state_d = TRACKING;
              end else begin
                good_d = good_inc;
              end
            end else begin
              ill_d  = 1'b1;
              err_d  = err_sat;
              good_d = '0;
            end
          end
          default: state_d = UNLOCKED;
        endcase
      end
    end else if (clr) begin
      pos_d = '0;
      err_d = '0;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= UNLOCKED;
      ref_q   <= '0;
      bin_q   <= '0;
      pos_q   <= '0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      ill_q   <= 1'b0;
      err_q   <= '0;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      bin_q   <= bin_d;
      pos_q   <= pos_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
      good_q  <= good_d;
    end
  end

  assign bin_out    = bin_q;
  assign pos_out    = pos_q;
  assign step_valid = step_q;
  assign dir_up     = dir_q;
  assign illegal    = ill_q;
  assign err_cnt    = err_q;
  assign locked     = (state_q == TRACKING);

endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed bench for gray_step_decoder (WIDTH=2, POS_W=8, ERR_W=4, RELOCK=3).
module tb_gray_step_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] gray_in = '0;
  logic       in_valid = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] bin_out;
  logic [7:0] pos_out;
  logic       step_valid;
  logic       dir_up;
  logic       illegal;
  logic [3:0] err_cnt;
  logic       locked;

  int checks = 0;
  int fails  = 0;

  gray_step_decoder #(.WIDTH(2), .POS_W(8), .ERR_W(4), .RELOCK(3)) dut (
    .clk(clk), .rst(rst), .gray_in(gray_in), .in_valid(in_valid), .clr(clr),
    .bin_out(bin_out), .pos_out(pos_out), .step_valid(step_valid),
    .dir_up(dir_up), .illegal(illegal), .err_cnt(err_cnt), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic exp_all(input string tag, input int b, input int p, input int sv,
                         input int dr, input int il, input int e, input int lk);
    chk({tag, ".bin"},   32'(bin_out),    b);
    chk({tag, ".pos"},   32'(pos_out),    p);
    chk({tag, ".step"},  32'(step_valid), sv);
    chk({tag, ".dir"},   32'(dir_up),     dr);
    chk({tag, ".ill"},   32'(illegal),    il);
    chk({tag, ".err"},   32'(err_cnt),    e);
    chk({tag, ".lock"},  32'(locked),     lk);
  endtask

  task automatic drive(input logic [1:0] g, input logic v, input logic c);
    @(negedge clk);
    rst = 1'b0; gray_in = g; in_valid = v; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst(input int n);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; clr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: count up
    do_rst(2);
    exp_all("rst", 0, 0, 0, 0, 0, 0, 0);
    drive(2'b00, 1, 0); exp_all("up0", 0, 0, 0, 0, 0, 0, 1);
    drive(2'b01, 1, 0); exp_all("up1", 1, 1, 1, 1, 0, 0, 1);
    drive(2'b11, 1, 0); exp_all("up2", 2, 2, 1, 1, 0, 0, 1);
    drive(2'b10, 1, 0); exp_all("up3", 3, 3, 1, 1, 0, 0, 1);
    drive(2'b00, 1, 0); exp_all("up4", 0, 4, 1, 1, 0, 0, 1);
    drive(2'b01, 1, 0); exp_all("up5", 1, 5, 1, 1, 0, 0, 1);

    // 2: count down, pos wraps below zero
    do_rst(1);
    drive(2'b00, 1, 0); exp_all("dn0", 0, 0,   0, 0, 0, 0, 1);
    drive(2'b10, 1, 0); exp_all("dn1", 3, 255, 1, 0, 0, 0, 1);
    drive(2'b11, 1, 0); exp_all("dn2", 2, 254, 1, 0, 0, 0, 1);
    drive(2'b01, 1, 0); exp_all("dn3", 1, 253, 1, 0, 0, 0, 1);
    drive(2'b00, 1, 0); exp_all("dn4", 0, 252, 1, 0, 0, 0, 1);

    // 3: illegal jump, fault, relock after three legal samples
    do_rst(1);
    drive(2'b01, 1, 0); exp_all("il0", 1, 0, 0, 0, 0, 0, 1);
    drive(2'b10, 1, 0); exp_all("il1", 3, 0, 0, 0, 1, 1, 0);
    drive(2'b11, 1, 0); exp_all("il2", 2, 0, 0, 0, 0, 1, 0);
    drive(2'b11, 1, 0); exp_all("il3", 2, 0, 0, 0, 0, 1, 0);
    drive(2'b01, 1, 0); exp_all("il4", 1, 0, 0, 0, 0, 1, 1);
    drive(2'b00, 1, 0); exp_all("il5", 0, 255, 1, 0, 0, 1, 1);

    // 4: error counter saturation on 20 alternating illegal jumps
    do_rst(1);
    drive(2'b00, 1, 0); exp_all("sat0", 0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      drive((k % 2 == 1) ? 2'b11 : 2'b00, 1, 0);
      chk($sformatf("sat%0d.ill", k), 32'(illegal), 1);
      chk($sformatf("sat%0d.err", k), 32'(err_cnt), (k < 15) ? k : 15);
    end
    chk("sat.lock", 32'(locked), 0);

    // 5: input gaps, clear with and without a sample
    do_rst(1);
    drive(2'b01, 1, 0); exp_all("gap0", 1, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      drive(2'b11, 0, 0);
      chk($sformatf("gap%0d.step", k), 32'(step_valid), 0);
      chk($sformatf("gap%0d.ill", k),  32'(illegal),    0);
      chk($sformatf("gap%0d.bin", k),  32'(bin_out),    1);
    end
    drive(2'b11, 1, 0); exp_all("gap1", 2, 1, 1, 1, 0, 0, 1);
    drive(2'b10, 1, 1); exp_all("clr0", 3, 0, 0, 1, 0, 0, 1);
    drive(2'b00, 1, 0); exp_all("clr1", 0, 1, 1, 1, 0, 0, 1);
    drive(2'b11, 1, 0); exp_all("clr2", 2, 1, 0, 1, 1, 1, 0);
    drive(2'b11, 0, 1); exp_all("clr3", 2, 0, 0, 1, 0, 0, 0);
    drive(2'b01, 1, 1); exp_all("clr4", 1, 0, 0, 1, 0, 0, 0);
    drive(2'b01, 1, 0); chk("clr5.lock", 32'(locked), 0);
    drive(2'b01, 1, 0); chk("clr6.lock", 32'(locked), 0);
    drive(2'b01, 1, 0); chk("clr7.lock", 32'(locked), 1);

    // 6: reset mid-operation with pos=3 and err=2
    do_rst(1);
    drive(2'b00, 1, 0);
    drive(2'b11, 1, 0);
    drive(2'b00, 1, 0);
    drive(2'b00, 1, 0);
    drive(2'b00, 1, 0);
    drive(2'b00, 1, 0); chk("mid.relock", 32'(locked), 1);
    drive(2'b01, 1, 0);
    drive(2'b11, 1, 0);
    drive(2'b10, 1, 0); exp_all("mid0", 3, 3, 1, 1, 0, 2, 1);
    do_rst(1);          exp_all("mid1", 0, 0, 0, 0, 0, 0, 0);
    drive(2'b11, 1, 0); exp_all("mid2", 2, 0, 0, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
